// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronise, debounce, qualify and queue coins.
// Ports: clk, rst, coin5_raw, coin10_raw, inhibit -> coin, reject, count, busy.
module coin_acceptor #(
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP        = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               coin5_raw,
   input  logic                               coin10_raw,
   input  logic                               inhibit,
   output logic [1:0]                         coin,
   output logic                               reject,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
   output logic                               busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
   localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

   typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

   logic s5_m, s5, s10_m, s10;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s5_m  <= 1'b0;
         s5    <= 1'b0;
         s10_m <= 1'b0;
         s10   <= 1'b0;
      end else begin
         s5_m  <= coin5_raw;
         s5    <= s5_m;
         s10_m <= coin10_raw;
         s10   <= s10_m;
      end
   end

   state_t        state, state_n;
   logic [DW-1:0] cnt, cnt_n, cnt_inc;
   logic          ctype, ctype_n;
   logic          qual, qual_n;
   logic          jam, jam_n;
   logic          same;

   assign cnt_inc = cnt + DW'(1);
   // latched coin still pressed alone (ctype=1 means 10-unit)
   assign same    = ctype ? (s10 & ~s5) : (s5 & ~s10);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HELD;
         cnt   <= '0;
         ctype <= 1'b0;
         qual  <= 1'b0;
         jam   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ctype <= ctype_n;
         qual  <= qual_n;
         jam   <= jam_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ctype_n = ctype;
      qual_n  = 1'b0;
      jam_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (s5 & s10) begin
               jam_n   = 1'b1;
               state_n = HELD;
               cnt_n   = '0;
            end else if (s5 ^ s10) begin
               ctype_n = s10;
               if (DEBOUNCE == 1) begin
                  qual_n  = 1'b1;
                  state_n = HELD;
                  cnt_n   = '0;
               end else begin
                  state_n = QUAL;
                  cnt_n   = DW'(1);
               end
            end
         end
         QUAL: begin
            if (same) begin
               if (cnt_inc == DW'(DEBOUNCE)) begin
                  qual_n  = 1'b1;
                  state_n = HELD;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         HELD: begin
            if (s5 | s10) begin
               cnt_n = '0;
            end else if (cnt_inc == DW'(DEBOUNCE)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         default: begin
            state_n = HELD;
            cnt_n   = '0;
         end
      endcase
   end

   logic [1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [GW-1:0] gcnt;
   logic          full, push, pop;

   // full is judged before any same-edge pop
   assign full = (count == CW'(FIFO_DEPTH));
   assign push = qual & ~inhibit & ~full;
   assign pop  = busy & (gcnt == '0);
   assign busy = (count != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= ctype ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         gcnt   <= '0;
         coin   <= 2'b00;
         reject <= 1'b0;
      end else begin
         reject <= jam | (qual & (inhibit | full));
         coin   <= pop ? mem[rptr] : 2'b00;
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         if (push & ~pop)      count <= count + CW'(1);
         else if (pop & ~push) count <= count - CW'(1);
         if (pop)               gcnt <= GW'(GAP);
         else if (gcnt != '0)   gcnt <= gcnt - GW'(1);
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: default instance (a) and GAP=60 instance (b).
// Edge index i counts rising edges after the stimulus is first applied.
module tb_coin_acceptor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       c5a = 1'b0, c10a = 1'b0, inha = 1'b0;
   logic       c5b = 1'b0, c10b = 1'b0, inhb = 1'b0;
   logic [1:0] coin_a, coin_b;
   logic       rej_a, rej_b, busy_a, busy_b;
   logic [2:0] cnt_a, cnt_b;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   coin_acceptor dut_a (
      .clk(clk), .rst(rst), .coin5_raw(c5a), .coin10_raw(c10a),
      .inhibit(inha), .coin(coin_a), .reject(rej_a),
      .count(cnt_a), .busy(busy_a)
   );

   coin_acceptor #(.GAP(60)) dut_b (
      .clk(clk), .rst(rst), .coin5_raw(c5b), .coin10_raw(c10b),
      .inhibit(inhb), .coin(coin_b), .reject(rej_b),
      .count(cnt_b), .busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      c5a = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (coin_a !== 2'b00 || rej_a !== 1'b0 || cnt_a !== 3'd0 || busy_a !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_hold coin=%b rej=%b cnt=%0d busy=%b want 00/0/0/0",
                  coin_a, rej_a, cnt_a, busy_a);
      end
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i == 20) c5a = 1'b0;
         tick();
         n_cmp++;
         if (coin_a !== 2'b00 || rej_a !== 1'b0 || cnt_a !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_release i=%0d coin=%b rej=%b cnt=%0d want 00/0/0",
                     i, coin_a, rej_a, cnt_a);
         end
      end
   endtask

   task automatic test_single();
      logic [1:0] ec;
      logic [2:0] en;
      for (int i = 0; i < 30; i++) begin
         c5a = (i < 6);
         tick();
         ec = (i == 7) ? 2'b01 : 2'b00;
         en = (i == 6) ? 3'd1 : 3'd0;
         n_cmp++;
         if (coin_a !== ec || cnt_a !== en || rej_a !== 1'b0 || busy_a !== (en != 0)) begin
            n_bad++;
            $display("FAIL single i=%0d coin=%b cnt=%0d rej=%b busy=%b want %b/%0d/0/%b",
                     i, coin_a, cnt_a, rej_a, busy_a, ec, en, en != 0);
         end
      end
   endtask

   task automatic test_glitch();
      logic [1:0] ec;
      for (int i = 0; i < 20; i++) begin
         c10a = (i < 3);
         tick();
         n_cmp++;
         if (coin_a !== 2'b00 || rej_a !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch i=%0d coin=%b rej=%b want 00/0", i, coin_a, rej_a);
         end
      end
      for (int i = 0; i < 30; i++) begin
         c10a = (i < 5);
         tick();
         ec = (i == 7) ? 2'b10 : 2'b00;
         n_cmp++;
         if (coin_a !== ec || rej_a !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_press i=%0d coin=%b rej=%b want %b/0", i, coin_a, rej_a, ec);
         end
      end
   endtask

   task automatic test_jam();
      for (int i = 0; i < 30; i++) begin
         c5a  = (i < 6);
         c10a = (i < 6);
         tick();
         n_cmp++;
         if (rej_a !== (i == 3) || coin_a !== 2'b00 || cnt_a !== 3'd0) begin
            n_bad++;
            $display("FAIL jam i=%0d rej=%b coin=%b cnt=%0d want %b/00/0",
                     i, rej_a, coin_a, cnt_a, i == 3);
         end
      end
   endtask

   task automatic test_inhibit();
      inha = 1'b1;
      for (int i = 0; i < 30; i++) begin
         c10a = (i < 5);
         tick();
         n_cmp++;
         if (rej_a !== (i == 6) || coin_a !== 2'b00 || cnt_a !== 3'd0) begin
            n_bad++;
            $display("FAIL inhibit i=%0d rej=%b coin=%b cnt=%0d want %b/00/0",
                     i, rej_a, coin_a, cnt_a, i == 6);
         end
      end
      inha = 1'b0;
   endtask

   task automatic test_overflow();
      logic [1:0] ec;
      logic [2:0] en;
      for (int i = 0; i < 300; i++) begin
         c10b = (i < 60) && (i % 10 < 5);
         tick();
         ec = (i == 7 || i == 68 || i == 129 || i == 190 || i == 251) ? 2'b10 : 2'b00;
         if (i < 6)        en = 3'd0;
         else if (i < 7)   en = 3'd1;
         else if (i < 16)  en = 3'd0;
         else if (i < 26)  en = 3'd1;
         else if (i < 36)  en = 3'd2;
         else if (i < 46)  en = 3'd3;
         else if (i < 68)  en = 3'd4;
         else if (i < 129) en = 3'd3;
         else if (i < 190) en = 3'd2;
         else if (i < 251) en = 3'd1;
         else              en = 3'd0;
         n_cmp++;
         if (coin_b !== ec || cnt_b !== en || rej_b !== (i == 56)) begin
            n_bad++;
            $display("FAIL overflow i=%0d coin=%b cnt=%0d rej=%b want %b/%0d/%b",
                     i, coin_b, cnt_b, rej_b, ec, en, i == 56);
         end
      end
      repeat (40) tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 40; i++) begin
         c10b = (i % 10 < 5);
         tick();
      end
      n_cmp++;
      if (cnt_b !== 3'd3 || busy_b !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_prefill cnt=%0d busy=%b want 3/1", cnt_b, busy_b);
      end
      c10b = 1'b0;
      rst  = 1'b1;
      #2;
      n_cmp++;
      if (cnt_b !== 3'd0 || busy_b !== 1'b0 || coin_b !== 2'b00) begin
         n_bad++;
         $display("FAIL mid_async cnt=%0d busy=%b coin=%b want 0/0/00", cnt_b, busy_b, coin_b);
      end
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 150; i++) begin
         tick();
         n_cmp++;
         if (coin_b !== 2'b00 || cnt_b !== 3'd0 || rej_b !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_after i=%0d coin=%b cnt=%0d rej=%b want 00/0/0",
                     i, coin_b, cnt_b, rej_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_jam();
      test_inhibit();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
